// File: rtl/clk2_matmul_consumer_pkg.sv
// clk2_matmul_consumer_pkg: shared types and constants for the clk2 matmul consumer.
// Holds the FSM state encoding, default widths and matrix geometry.
package clk2_matmul_consumer_pkg;

    // FSM state encoding
    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_t;

    // Default widths
    localparam int IN_W_DEF   = 8;
    localparam int ELEM_W_DEF = 4;
    localparam int OUT_W_DEF  = 10;

    // Matrix geometry: DIM x DIM, row-major
    localparam int DIM   = 4;
    localparam int NELEM = DIM * DIM;
    localparam int CNT_W = $clog2(NELEM);

endpackage

// File: rtl/clk2_matmul_consumer_dot4.sv
// clk2_matmul_consumer_dot4: combinational 4-term unsigned dot product.
// Ports: a0..a3, b0..b3 (ELEM_W each) in; sum (OUT_W) out.
module clk2_dot4
    import clk2_matmul_consumer_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic [ELEM_W-1:0] a0,
    input  logic [ELEM_W-1:0] a1,
    input  logic [ELEM_W-1:0] a2,
    input  logic [ELEM_W-1:0] a3,
    input  logic [ELEM_W-1:0] b0,
    input  logic [ELEM_W-1:0] b1,
    input  logic [ELEM_W-1:0] b2,
    input  logic [ELEM_W-1:0] b3,
    output logic [OUT_W-1:0]  sum
);

    // Full-width products; no truncation before the sum
    logic [2*ELEM_W-1:0] p0;
    logic [2*ELEM_W-1:0] p1;
    logic [2*ELEM_W-1:0] p2;
    logic [2*ELEM_W-1:0] p3;

    assign p0 = a0 * b0;
    assign p1 = a1 * b1;
    assign p2 = a2 * b2;
    assign p3 = a3 * b3;

    assign sum = OUT_W'(p0) + OUT_W'(p1) + OUT_W'(p2) + OUT_W'(p3);

endmodule

// File: rtl/clk2_matmul_consumer.sv
// clk2_matmul_consumer: collects 16 A/B element pairs, then writes C = A x B
// to an async FIFO one element per cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   in_valid, in_data synchronizer dvalid/dout ({A[k], B[k]})
//   busy              high while emitting (to synchronizer dbusy)
//   fifo_full         FIFO write-side full
//   fifo_winc         registered FIFO write enable
//   fifo_wdata        registered FIFO write data
//   err_drop          (only with CLK2_DROP_ERR_EN) sticky flag for
//                     in_valid rising edges dropped during EMIT
module clk2_matmul_consumer
    import clk2_matmul_consumer_pkg::*;
#(
    parameter int IN_W   = IN_W_DEF,
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int OUT_W  = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             busy,
    input  logic             fifo_full,
    output logic             fifo_winc,
    output logic [OUT_W-1:0] fifo_wdata
`ifdef CLK2_DROP_ERR_EN
    ,
    output logic             err_drop
`endif
);

    state_t state;
    state_t state_nxt;

    logic             in_valid_d;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] emit_idx;

    logic [ELEM_W-1:0] a_mem [NELEM];
    logic [ELEM_W-1:0] b_mem [NELEM];

    logic rise;
    logic accept;
    logic issue;
    logic last_word;
    logic last_emit;

    logic [1:0]       row;
    logic [1:0]       col;
    logic [OUT_W-1:0] dot;

    // A held level counts once: only the rising edge of in_valid is a word
    assign rise      = in_valid & ~in_valid_d;
    assign accept    = rise & (state == COLLECT);
    assign issue     = (state == EMIT) & ~fifo_full;
    assign last_word = (word_cnt == CNT_W'(NELEM - 1));
    assign last_emit = (emit_idx == CNT_W'(NELEM - 1));

    assign busy = (state == EMIT);

    // Current output element C[row][col]
    assign row = emit_idx[3:2];
    assign col = emit_idx[1:0];

    clk2_dot4 #(
        .ELEM_W (ELEM_W),
        .OUT_W  (OUT_W)
    ) u_dot (
        .a0  (a_mem[{row, 2'd0}]),
        .a1  (a_mem[{row, 2'd1}]),
        .a2  (a_mem[{row, 2'd2}]),
        .a3  (a_mem[{row, 2'd3}]),
        .b0  (b_mem[{2'd0, col}]),
        .b1  (b_mem[{2'd1, col}]),
        .b2  (b_mem[{2'd2, col}]),
        .b3  (b_mem[{2'd3, col}]),
        .sum (dot)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: begin
                if (accept && last_word) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (issue && last_emit) begin
                    state_nxt = COLLECT;
                end
            end
            default: begin
                state_nxt = COLLECT;
            end
        endcase
    end

    // Capture path: edge detector, word counter, A/B storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_d <= 1'b0;
            word_cnt   <= '0;
            for (int k = 0; k < NELEM; k++) begin
                a_mem[k] <= '0;
                b_mem[k] <= '0;
            end
        end else begin
            in_valid_d <= in_valid;
            if (accept) begin
                a_mem[word_cnt] <= in_data[2*ELEM_W-1:ELEM_W];
                b_mem[word_cnt] <= in_data[ELEM_W-1:0];
                // Wraps to 0 on word 15, ready for the next job
                word_cnt        <= word_cnt + 1'b1;
            end
        end
    end

    // Emit path: registered FIFO write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            emit_idx   <= '0;
            fifo_winc  <= 1'b0;
            fifo_wdata <= '0;
        end else if (state == COLLECT) begin
            fifo_winc  <= 1'b0;
            fifo_wdata <= '0;
        end else if (issue) begin
            fifo_winc  <= 1'b1;
            fifo_wdata <= dot;
            emit_idx   <= emit_idx + 1'b1;
        end else begin
            // FIFO full: stall with data and index held
            fifo_winc  <= 1'b0;
        end
    end

`ifdef CLK2_DROP_ERR_EN
    // Sticky: a new transfer arrived while the previous job was draining
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_drop <= 1'b0;
        end else if (rise && (state == EMIT)) begin
            err_drop <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_clk2_matmul_consumer.sv
// tb_clk2_matmul_consumer: table-driven and randomized jobs checked against
// a plain matrix-multiply reference, plus stall, drop and reset sequences.
module tb_clk2_matmul_consumer;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b1;
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'd0;
    logic       fifo_full = 1'b0;
    logic       busy;
    logic       fifo_winc;
    logic [9:0] fifo_wdata;
`ifdef CLK2_DROP_ERR_EN
    logic       err_drop;
`endif

    clk2_matmul_consumer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_winc  (fifo_winc),
        .fifo_wdata (fifo_wdata)
`ifdef CLK2_DROP_ERR_EN
        ,
        .err_drop   (err_drop)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0][3:0] a;
        logic [15:0][3:0] b;
        int hi;
        int lo;
        int stall_at;
        int stall_len;
        int exp_c0;
        int exp_c15;
    } vec_t;

    vec_t tbl [5];
    vec_t v;

    int checks = 0;
    int errors = 0;

    int wq [$];
    int cyc        = 0;
    int first_w    = -1;
    int last_w     = -1;
    int busy_cnt   = 0;
    int cap_cyc    = 0;
    int stall_at   = -1;
    int stall_len  = 0;
    int stall_left = 0;
    bit stall_done = 1'b0;
    int exp_c [16];

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: C = A x B by definition
    function automatic void model(input vec_t m);
        int s;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                s = 0;
                for (int t = 0; t < 4; t++) begin
                    s += int'(m.a[4*i+t]) * int'(m.b[4*t+j]);
                end
                exp_c[4*i+j] = s;
            end
        end
    endfunction

    // One clock: sample outputs 1 time unit after the edge, drive stall
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (fifo_winc) begin
            wq.push_back(int'(fifo_wdata));
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
        end
        if (busy) busy_cnt++;
        if (stall_at >= 0 && !stall_done && wq.size() == stall_at) begin
            fifo_full  = 1'b1;
            stall_left = stall_len;
            stall_done = 1'b1;
        end else if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) fifo_full = 1'b0;
        end
    endtask

    task automatic send_words(input vec_t m, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = {m.a[k], m.b[k]};
            tick();
            if (k == 15) cap_cyc = cyc;
            repeat (m.hi - 1) tick();
            in_valid = 1'b0;
            in_data  = 8'd0;
            repeat (m.lo) tick();
        end
    endtask

    task automatic run_job(input vec_t m, input bit pulse);
        int n;
        int stl;
        bit pulsed;
        wq.delete();
        first_w    = -1;
        last_w     = -1;
        busy_cnt   = 0;
        fifo_full  = 1'b0;
        stall_at   = m.stall_at;
        stall_len  = m.stall_len;
        stall_left = 0;
        stall_done = 1'b0;
        pulsed     = 1'b0;
        stl        = (m.stall_at >= 0) ? m.stall_len : 0;
        model(m);
        send_words(m, 16);
        n = 0;
        while (busy && n < 200) begin
            if (pulse && !pulsed) begin
                in_valid = 1'b1;
                in_data  = 8'hFF;
                tick();
                in_valid = 1'b0;
                in_data  = 8'd0;
                pulsed   = 1'b1;
            end else begin
                tick();
            end
            n++;
        end
        chk("busy_timeout", int'(busy), 0);
        repeat (3) tick();
        chk("nwrites", wq.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < wq.size()) chk($sformatf("wdata[%0d]", i), wq[i], exp_c[i]);
        end
        chk("latency", first_w, cap_cyc + 1);
        chk("span", last_w - first_w + 1, 16 + stl);
        chk("busy_cycles", busy_cnt, 16 + stl);
        if (m.exp_c0 >= 0 && wq.size() == 16) begin
            chk("c0_const", wq[0], m.exp_c0);
            chk("c15_const", wq[15], m.exp_c15);
        end
    endtask

    task automatic rand_fill(output vec_t m, input int hi, input int lo);
        for (int k = 0; k < 16; k++) begin
            m.a[k] = 4'($urandom_range(0, 15));
            m.b[k] = 4'($urandom_range(0, 15));
        end
        m.hi        = hi;
        m.lo        = lo;
        m.stall_at  = -1;
        m.stall_len = 0;
        m.exp_c0    = -1;
        m.exp_c15   = -1;
    endtask

    // Pull rst_n low between edges and check outputs without a clock edge
    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_winc"}, int'(fifo_winc), 0);
        chk({tag, "_wdata"}, int'(fifo_wdata), 0);
`ifdef CLK2_DROP_ERR_EN
        chk({tag, "_err_drop"}, int'(err_drop), 0);
`endif
        #2;
        rst_n = 1'b1;
        fifo_full = 1'b0;
        tick();
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        // Table: identity x ramp, all-15, 3-high/2-low pacing, FIFO stall
        for (int k = 0; k < 16; k++) begin
            tbl[0].a[k] = (k == 0 || k == 5 || k == 10 || k == 15) ? 4'd1 : 4'd0;
            tbl[0].b[k] = 4'(k);
        end
        tbl[0].hi = 1; tbl[0].lo = 1; tbl[0].stall_at = -1; tbl[0].stall_len = 0;
        tbl[0].exp_c0 = 0; tbl[0].exp_c15 = 15;
        for (int k = 0; k < 16; k++) begin
            tbl[1].a[k] = 4'd15;
            tbl[1].b[k] = 4'd15;
        end
        tbl[1].hi = 1; tbl[1].lo = 1; tbl[1].stall_at = -1; tbl[1].stall_len = 0;
        tbl[1].exp_c0 = 900; tbl[1].exp_c15 = 900;
        rand_fill(tbl[2], 3, 2);
        rand_fill(tbl[3], 1, 1);
        tbl[3].stall_at = 4; tbl[3].stall_len = 5;
        rand_fill(tbl[4], 2, 3);

        #1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_winc", int'(fifo_winc), 0);
        chk("rst_wdata", int'(fifo_wdata), 0);
`ifdef CLK2_DROP_ERR_EN
        chk("rst_err_drop", int'(err_drop), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int r = 0; r < 5; r++) run_job(tbl[r], 1'b0);

        for (int r = 0; r < 3; r++) begin
            rand_fill(v, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            run_job(v, 1'b0);
        end

`ifdef CLK2_DROP_ERR_EN
        chk("err_drop_clear", int'(err_drop), 0);
`endif
        // in_valid edge during EMIT: must be dropped, next job starts at word 0
        rand_fill(v, 1, 1);
        run_job(v, 1'b1);
`ifdef CLK2_DROP_ERR_EN
        chk("err_drop_set", int'(err_drop), 1);
`endif
        rand_fill(v, 1, 2);
        run_job(v, 1'b0);
`ifdef CLK2_DROP_ERR_EN
        chk("err_drop_sticky", int'(err_drop), 1);
`endif

        // Abort after 9 captures, then a clean job
        rand_fill(v, 1, 1);
        send_words(v, 9);
        async_reset("abort_collect");
        rand_fill(v, 2, 1);
        run_job(v, 1'b0);

        // Abort in the middle of emitting, then a clean job
        rand_fill(v, 1, 1);
        wq.delete();
        send_words(v, 16);
        for (int n = 0; n < 50 && wq.size() < 3; n++) tick();
        chk("abort_emit_busy_pre", int'(busy), 1);
        async_reset("abort_emit");
        rand_fill(v, 1, 1);
        run_job(v, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
